// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory subsystem.
//   - access size encodings carried in sign_mask[1:0]
//   - FSM state and load-source enums
//   - MMIO register offsets relative to MMIO_BASE
//   - load_align: lane extraction plus sign/zero extension for RAM loads
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] GPIO_OFFSET  = 32'h0000_0000;
  localparam logic [31:0] CYCLE_OFFSET = 32'h0000_0100;

  typedef enum logic {IDLE, WAIT} state_e;

  // Where the captured load result comes from; SRC_NONE yields zero (error reads).
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_MMIO} src_e;

  function automatic logic [31:0] load_align(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size,
                                             input logic        zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (off)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = zext ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = zext ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_subsys_ram.sv
// ram_bytelane: DEPTH_WORDS x 32 single-port RAM with per-byte write enables
// and a one-cycle registered read. Contents are never reset.
//   clk   : clock
//   we    : write enable, be selects byte lanes
//   re    : read enable, rdata updates at the next edge and holds otherwise
//   addr  : word address
//   wdata : write data, already placed on its lanes
//   rdata : registered read data
module ram_bytelane #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_subsys.sv
// data_mem_subsys: CPU data-port memory subsystem.
//   Byte-lane RAM, GPIO output register bank and a free-running cycle counter,
//   with sized sign/zero-extended loads, READ_LATENCY-cycle read return and
//   error pulses on misaligned, illegal-size or undecoded accesses.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   addr, write_data    : byte address, right-aligned store data
//   memwrite, memread   : request strobes (both high = write)
//   sign_mask           : [1:0] size, [2] zero-extend, [3] ignored
//   ready               : request accepted when high
//   read_data, rvalid   : load result and its one-cycle valid pulse
//   err                 : one-cycle error pulse the cycle after accept
//   gpio_out            : GPIO registers, register 0 in the LSBs
module data_mem_subsys
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned NUM_GPIO     = 1,
  parameter int unsigned GPIO_W       = 8,
  parameter logic [31:0] MMIO_BASE    = 32'h0000_2000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                addr,
  input  logic [31:0]                write_data,
  input  logic                       memwrite,
  input  logic                       memread,
  input  logic [3:0]                 sign_mask,
  output logic                       ready,
  output logic [31:0]                read_data,
  output logic                       rvalid,
  output logic                       err,
  output logic [NUM_GPIO*GPIO_W-1:0] gpio_out
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] GPIO_BASE = MMIO_BASE + GPIO_OFFSET;
  localparam logic [31:0] GPIO_SPAN = 32'(4 * NUM_GPIO);
  localparam logic [31:0] CNT_ADDR  = MMIO_BASE + CYCLE_OFFSET;
  localparam logic [2:0]  LAT_INIT  = 3'(READ_LATENCY - 1);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [1:0]  size;
  logic        zext;
  logic [31:0] gpio_off;
  logic        ram_hit, gpio_hit, cnt_hit, misalign, bad;
  logic        accept, wr_acc, rd_acc;
  logic        unused_sign_mask;

  assign size             = sign_mask[1:0];
  assign zext             = sign_mask[2];
  assign unused_sign_mask = sign_mask[3];
  assign gpio_off         = addr - GPIO_BASE;

  // RAM wins any overlap with the MMIO window.
  assign ram_hit  = addr < RAM_BYTES;
  assign gpio_hit = !ram_hit && (addr >= GPIO_BASE) && (gpio_off < GPIO_SPAN) &&
                    (gpio_off[1:0] == 2'b00);
  assign cnt_hit  = !ram_hit && !gpio_hit && (addr == CNT_ADDR);
  assign misalign = ((size == SZ_HALF) && addr[0]) ||
                    ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign bad      = (size == 2'b11) || misalign || !(ram_hit || gpio_hit || cnt_hit);

  assign accept = ready && (memread || memwrite);
  assign wr_acc = accept && memwrite;
  assign rd_acc = accept && memread && !memwrite;

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_we, ram_re;

  always_comb begin
    ram_be    = 4'b1111;
    ram_wdata = write_data;
    case (size)
      SZ_BYTE: begin
        ram_be    = 4'b0001 << addr[1:0];
        ram_wdata = {4{write_data[7:0]}};
      end
      SZ_HALF: begin
        ram_be    = addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ram_we = wr_acc && ram_hit && !bad;
  assign ram_re = rd_acc && ram_hit && !bad;

  ram_bytelane #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .be   (ram_be),
    .addr (addr[AW+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // GPIO bank and cycle counter
  // ---------------------------------------------------------------------------
  logic [GPIO_W-1:0] gpio_q [NUM_GPIO];
  logic [31:0]       gpio_rd;
  logic [31:0]       cnt_q;

  always_comb begin
    gpio_rd = '0;
    for (int k = 0; k < NUM_GPIO; k++) begin
      if (gpio_off[31:2] == 30'(k)) gpio_rd = 32'(gpio_q[k]);
    end
  end

  always_comb begin
    gpio_out = '0;
    for (int k = 0; k < NUM_GPIO; k++) gpio_out[k*GPIO_W +: GPIO_W] = gpio_q[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_GPIO; k++) gpio_q[k] <= '0;
    end else if (wr_acc && gpio_hit && !bad) begin
      for (int k = 0; k < NUM_GPIO; k++) begin
        if (gpio_off[31:2] == 30'(k)) gpio_q[k] <= write_data[GPIO_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_q + 32'd1;
  end

  // ---------------------------------------------------------------------------
  // Load capture (first stage, aligned with the RAM's registered read)
  // ---------------------------------------------------------------------------
  logic        v0_q, err_q, zext_q;
  src_e        src_q;
  logic [1:0]  off_q, size_q;
  logic [31:0] mmio_q, res0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      err_q  <= 1'b0;
      src_q  <= SRC_NONE;
      off_q  <= 2'b00;
      size_q <= SZ_WORD;
      zext_q <= 1'b0;
      mmio_q <= '0;
    end else begin
      v0_q  <= rd_acc;
      err_q <= accept && bad;
      if (rd_acc) begin
        src_q  <= bad ? SRC_NONE : (ram_hit ? SRC_RAM : SRC_MMIO);
        off_q  <= addr[1:0];
        size_q <= size;
        zext_q <= zext;
        mmio_q <= cnt_hit ? cnt_q : gpio_rd;
      end
    end
  end

  always_comb begin
    case (src_q)
      SRC_RAM:  res0 = load_align(ram_rdata, off_q, size_q, zext_q);
      SRC_MMIO: res0 = mmio_q;
      default:  res0 = '0;
    endcase
  end

  assign err = err_q;

  // ---------------------------------------------------------------------------
  // Extra output stages for READ_LATENCY > 1; each holds its data between loads.
  // ---------------------------------------------------------------------------
  if (READ_LATENCY > 1) begin : g_pipe
    logic [31:0] pd_q [READ_LATENCY-1];
    logic        pv_q [READ_LATENCY-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
          pv_q[i] <= 1'b0;
          pd_q[i] <= '0;
        end
      end else begin
        pv_q[0] <= v0_q;
        if (v0_q) pd_q[0] <= res0;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          pv_q[i] <= pv_q[i-1];
          if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
        end
      end
    end

    assign rvalid    = pv_q[READ_LATENCY-2];
    assign read_data = pd_q[READ_LATENCY-2];
  end else begin : g_nopipe
    assign rvalid    = v0_q;
    assign read_data = res0;
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM: blocks new requests while a multi-cycle read is in flight
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [2:0] lat_q, lat_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (rd_acc && (READ_LATENCY > 1)) begin
          state_d = WAIT;
          lat_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_q == 3'd1) state_d = IDLE;
        else               lat_d   = lat_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
  end

endmodule
